uart_boot_server: RTL and testbench
===================================

// Module: uart_boot_server
// PURPOSE
//  Host-side end of the UART boot protocol, protocol layer only (byte-level UART cores attach outside).
//  Waits for CPU sync 0x99, sends the 4-byte little-endian program size, then the program bytes.
//  Waits for CPU sync 0xAA, then streams buffered stdin bytes to the CPU and forwards CPU stdout bytes.
//  Used in the board-to-board loader and as the CPU-facing peer in system simulation.
// PARAMETERS
//  ADDR_W          17           byte-address width of the program ROM port
//  FIFO_DEPTH      16           stdin FIFO entries, power of 2, >=2
//  TIMEOUT_CYCLES  100_000_000  watchdog limit, used only with BOOT_SERVER_TIMEOUT_EN
// PORTS
//  clk            in   1       clock
//  reset_n        in   1       synchronous, active-low reset
//  start          in   1       begin session; sampled only in IDLE
//  prog_size      in   32      program length in bytes; latched on accepted start
//  prog_rd_addr   out  ADDR_W  ROM byte address
//  prog_rd_data   in   8       ROM byte, valid 1 cycle after prog_rd_addr
//  rx_data        in   8       byte from UART receiver
//  rx_ready       in   1       1-cycle strobe, rx_data valid
//  tx_data        out  8       byte to UART transmitter, held stable while tx_busy
//  tx_start       out  1       1-cycle launch pulse
//  tx_busy        in   1       transmitter busy; must rise within 1 cycle of tx_start
//  stdin_wr_en    in   1       push stdin_wr_data into stdin FIFO
//  stdin_wr_data  in   8       stdin byte
//  stdin_full     out  1       FIFO full
//  stdout_valid   out  1       1-cycle strobe, stdout_data valid
//  stdout_data    out  8       byte received from CPU in STREAM
//  boot_done      out  1       high from 0xAA received until reset
//  proto_err      out  1       sticky: unexpected byte before STREAM, or stdin push while full
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, FIFO flushed, counters cleared; reset mid-session aborts immediately.
//  States: IDLE -start-> WAIT_99 -rx 0x99-> SEND_SIZE -4 bytes sent-> SEND_PROG -prog_size bytes-> WAIT_AA
//    -rx 0xAA-> STREAM (terminal until reset). prog_size==0: SEND_SIZE goes directly to WAIT_AA.
//  start outside IDLE ignored. In WAIT_99/WAIT_AA any other byte sets proto_err, state unchanged.
//  Any rx byte in SEND_SIZE/SEND_PROG sets proto_err and is dropped.
//  TX rule: tx_start only when tx_start==0 and tx_busy==0 (one idle gap cycle between launches).
//  SEND_SIZE: bytes prog_size[7:0],[15:8],[23:16],[31:24] in that order.
//  SEND_PROG: addr k on prog_rd_addr, launch prog_rd_data next cycle; k runs 0..prog_size-1,
//    32-bit byte counter, prog_rd_addr = counter[ADDR_W-1:0] (wraps silently above 2^ADDR_W).
//  stdin FIFO accepts pushes in every non-reset state; push while full dropped and sets proto_err.
//    Simultaneous push+pop legal when not full; count unchanged.
//  STREAM: pop and launch one FIFO byte whenever TX rule allows; empty FIFO -> no launch.
//  STREAM rx: stdout_valid=1, stdout_data=rx_data in the cycle after rx_ready, every byte incl. 0x99/0xAA.
//  STREAM TX and RX are independent; full duplex.
// CONFIGURATION
//  BOOT_SERVER_TIMEOUT_EN defined: cycle counter runs in WAIT_99/WAIT_AA, cleared on state entry;
//    at TIMEOUT_CYCLES sets proto_err and returns to IDLE (FIFO kept).
//  Undefined: no counter, waits forever; TIMEOUT_CYCLES unused.
// STRUCTURE
//  boot_server_pkg: state enum, SYNC_START=8'h99, SYNC_DONE=8'hAA, SIZE_BYTES=4.
//  Sub-module boot_byte_fifo (DEPTH, 8-bit, push/pop/full/empty/dout); FSM and TX sequencer in top.
// TESTING
//  prog_size=8, ROM=01..08, rx 0x99 -> tx 08,00,00,00,01..08 in order, then WAIT_AA.
//  Then rx 0xAA -> boot_done=1; push 'h','i' -> tx 0x68,0x69; rx 0x41 -> stdout_valid, stdout_data=0x41.
//  prog_size=0: rx 0x99 -> tx 00,00,00,00 only; rx 0xAA -> boot_done=1.
//  rx 0x55 in WAIT_99 -> proto_err=1, state WAIT_99; later 0x99 still proceeds.
//  17 pushes into 16-deep FIFO before STREAM -> stdin_full, proto_err, exactly 16 bytes sent after 0xAA.
//  reset_n low mid SEND_PROG -> next cycle all outputs 0, IDLE; restart sends full sequence from byte 0.
//  TIMEOUT_EN, TIMEOUT_CYCLES=100: no 0x99 for 100 cycles -> proto_err=1, state IDLE.

Source files
------------

// File: rtl/boot_server_pkg.sv
// Shared types and constants for the UART boot server.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package boot_server_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_99   = 3'd1,
        SEND_SIZE = 3'd2,
        SEND_PROG = 3'd3,
        WAIT_AA   = 3'd4,
        STREAM    = 3'd5
    } state_t;

    localparam logic [7:0] SYNC_START = 8'h99;
    localparam logic [7:0] SYNC_DONE  = 8'hAA;
    localparam int         SIZE_BYTES = 4;

endpackage

// File: rtl/boot_byte_fifo.sv
// Generic show-ahead FIFO; dout presents the oldest entry while not empty.
// Latency: push visible on dout the cycle after it is written.
// Backpressure: push ignored while full, pop ignored while empty.
module boot_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_boot_server.sv
// Host side of the UART boot protocol: size + program download, then stdin/stdout streaming.
// Latency: tx launch one cycle after decision, stdout one cycle after rx_ready; optional watchdog via BOOT_SERVER_TIMEOUT_EN.
// Backpressure: launches gated by tx_busy with one idle gap; stdin pushes while full are dropped and flagged.
module uart_boot_server
    import boot_server_pkg::*;
#(
    parameter int ADDR_W         = 17,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [31:0]       prog_size,
    output logic [ADDR_W-1:0] prog_rd_addr,
    input  logic [7:0]        prog_rd_data,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    input  logic              stdin_wr_en,
    input  logic [7:0]        stdin_wr_data,
    output logic              stdin_full,
    output logic              stdout_valid,
    output logic [7:0]        stdout_data,
    output logic              boot_done,
    output logic              proto_err
);
    state_t      state;
    state_t      state_nxt;
    logic [31:0] size_q;
    logic [31:0] byte_cnt;
    logic [1:0]  size_idx;
    logic        addr_ok;
    logic        can_launch;
    logic        launch;
    logic [7:0]  launch_dat;
    logic [7:0]  size_byte;
    logic        fifo_pop;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic        err_set;
    logic        prog_last;
    logic        start_ok;
    logic        tmo_hit;

    boot_byte_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_stdin_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (stdin_wr_en),
        .din     (stdin_wr_data),
        .pop     (fifo_pop),
        .dout    (fifo_dout),
        .full    (stdin_full),
        .empty   (fifo_empty)
    );

    assign can_launch   = !tx_start && !tx_busy;
    assign prog_last    = (byte_cnt + 32'd1) == size_q;
    assign prog_rd_addr = byte_cnt[ADDR_W-1:0];
    assign start_ok     = (state == IDLE) && start;

    always_comb begin
        size_byte = size_q[7:0];
        case (size_idx)
            2'd1:    size_byte = size_q[15:8];
            2'd2:    size_byte = size_q[23:16];
            2'd3:    size_byte = size_q[31:24];
            default: size_byte = size_q[7:0];
        endcase
    end

    always_comb begin
        state_nxt  = state;
        launch     = 1'b0;
        launch_dat = 8'h00;
        fifo_pop   = 1'b0;
        err_set    = stdin_wr_en && stdin_full;
        case (state)
            IDLE: begin
                if (start)    state_nxt = WAIT_99;
                if (rx_ready) err_set   = 1'b1;
            end
            WAIT_99: begin
                if (rx_ready) begin
                    if (rx_data == SYNC_START) state_nxt = SEND_SIZE;
                    else                       err_set   = 1'b1;
                end
            end
            SEND_SIZE: begin
                if (rx_ready) err_set = 1'b1;
                if (can_launch) begin
                    launch     = 1'b1;
                    launch_dat = size_byte;
                    if (size_idx == 2'(SIZE_BYTES - 1))
                        state_nxt = (size_q == 32'd0) ? WAIT_AA : SEND_PROG;
                end
            end
            SEND_PROG: begin
                if (rx_ready) err_set = 1'b1;
                // addr_ok guarantees the ROM has had a cycle to respond to the current address.
                if (can_launch && addr_ok) begin
                    launch     = 1'b1;
                    launch_dat = prog_rd_data;
                    if (prog_last) state_nxt = WAIT_AA;
                end
            end
            WAIT_AA: begin
                if (rx_ready) begin
                    if (rx_data == SYNC_DONE) state_nxt = STREAM;
                    else                      err_set   = 1'b1;
                end
            end
            STREAM: begin
                if (can_launch && !fifo_empty) begin
                    launch     = 1'b1;
                    launch_dat = fifo_dout;
                    fifo_pop   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (tmo_hit) begin
            state_nxt = IDLE;
            err_set   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            size_q       <= '0;
            byte_cnt     <= '0;
            size_idx     <= '0;
            addr_ok      <= 1'b0;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            stdout_valid <= 1'b0;
            stdout_data  <= '0;
            boot_done    <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            tx_start     <= launch;
            stdout_valid <= (state == STREAM) && rx_ready;
            if (launch) tx_data <= launch_dat;
            if ((state == STREAM) && rx_ready) stdout_data <= rx_data;
            if (err_set) proto_err <= 1'b1;
            if ((state == WAIT_AA) && (state_nxt == STREAM)) boot_done <= 1'b1;
            if ((state == SEND_SIZE) && launch) size_idx <= size_idx + 2'd1;
            if (start_ok) begin
                size_q   <= prog_size;
                byte_cnt <= '0;
                size_idx <= '0;
                addr_ok  <= 1'b0;
            end else if ((state == SEND_PROG) && launch) begin
                byte_cnt <= byte_cnt + 32'd1;
                addr_ok  <= 1'b0;
            end else begin
                addr_ok  <= 1'b1;
            end
        end
    end

`ifdef BOOT_SERVER_TIMEOUT_EN
    logic [31:0] tmo_cnt;
    logic        in_wait;

    assign in_wait = (state == WAIT_99) || (state == WAIT_AA);
    assign tmo_hit = in_wait && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset_n || !in_wait || (state_nxt != state)) tmo_cnt <= '0;
        else                                              tmo_cnt <= tmo_cnt + 32'd1;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign tmo_hit = 1'b0;
`endif

endmodule

// File: tb/tb_uart_boot_server.sv
// Directed self-checking bench for uart_boot_server with a ROM model and a busy-stretching transmitter model.
module tb_uart_boot_server;
    import boot_server_pkg::*;

    localparam int ADDR_W = 17;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [31:0]       prog_size = '0;
    logic [ADDR_W-1:0] prog_rd_addr;
    logic [7:0]        prog_rd_data = '0;
    logic [7:0]        rx_data = '0;
    logic              rx_ready = 1'b0;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy = 1'b0;
    logic              stdin_wr_en = 1'b0;
    logic [7:0]        stdin_wr_data = '0;
    logic              stdin_full;
    logic              stdout_valid;
    logic [7:0]        stdout_data;
    logic              boot_done;
    logic              proto_err;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] rom [256];
    logic [7:0] tx_q [$];
    int         tx_base = 0;
    int         busy_cnt = 0;

    uart_boot_server #(.ADDR_W(ADDR_W), .FIFO_DEPTH(16), .TIMEOUT_CYCLES(100)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .prog_size     (prog_size),
        .prog_rd_addr  (prog_rd_addr),
        .prog_rd_data  (prog_rd_data),
        .rx_data       (rx_data),
        .rx_ready      (rx_ready),
        .tx_data       (tx_data),
        .tx_start      (tx_start),
        .tx_busy       (tx_busy),
        .stdin_wr_en   (stdin_wr_en),
        .stdin_wr_data (stdin_wr_data),
        .stdin_full    (stdin_full),
        .stdout_valid  (stdout_valid),
        .stdout_data   (stdout_data),
        .boot_done     (boot_done),
        .proto_err     (proto_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) prog_rd_data <= rom[prog_rd_addr[7:0]];

    // Transmitter: captures each launched byte and stays busy for three cycles.
    always @(posedge clk) begin
        if (tx_start) begin
            tx_q.push_back(tx_data);
            tx_busy  <= 1'b1;
            busy_cnt <= 3;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            busy_cnt <= 0;
            tx_busy  <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        cycles(2);
        reset_n = 1'b1;
        tx_base = tx_q.size();
    endtask

    task automatic do_start(input logic [31:0] size);
        @(negedge clk);
        prog_size = size;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic push_stdin(input logic [7:0] b);
        @(negedge clk);
        stdin_wr_data = b;
        stdin_wr_en   = 1'b1;
        @(negedge clk);
        stdin_wr_en   = 1'b0;
    endtask

    task automatic wait_tx(input int n, input string tag);
        int budget = 2000;
        while ((tx_q.size() < tx_base + n) && (budget > 0)) begin
            @(negedge clk);
            budget--;
        end
        check(tag, 32'(tx_q.size() >= tx_base + n), 32'd1);
    endtask

    // Size bytes are little-endian prog_size, program bytes are k+1 from the ROM model.
    task automatic check_boot_seq(input logic [31:0] size, input string tag);
        logic [7:0] exp;
        for (int i = 0; i < 4 + int'(size); i++) begin
            exp = (i < 4) ? 8'(size >> (8 * i)) : 8'(i - 3);
            check($sformatf("%s_byte%0d", tag, i), 32'(tx_q[tx_base + i]), 32'(exp));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'(i + 1);

        // Reset state
        cycles(3);
        check("rst_tx_start",  32'(tx_start), 32'd0);
        check("rst_tx_data",   32'(tx_data), 32'd0);
        check("rst_boot_done", 32'(boot_done), 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);
        check("rst_full",      32'(stdin_full), 32'd0);
        check("rst_stdout_v",  32'(stdout_valid), 32'd0);
        check("rst_addr",      32'(prog_rd_addr), 32'd0);
        check("rst_state",     32'(dut.state), 32'(IDLE));
        reset_n = 1'b1;
        tx_base = tx_q.size();

        // 8-byte program download and streaming
        do_start(32'd8);
        check("a_wait99", 32'(dut.state), 32'(WAIT_99));
        send_rx(SYNC_START);
        wait_tx(12, "a_tx_count");
        check_boot_seq(32'd8, "a");
        cycles(2);
        check("a_wait_aa", 32'(dut.state), 32'(WAIT_AA));
        check("a_no_err",  32'(proto_err), 32'd0);
        send_rx(SYNC_DONE);
        check("a_boot_done", 32'(boot_done), 32'd1);
        check("a_stream",    32'(dut.state), 32'(STREAM));
        tx_base = tx_q.size();
        push_stdin(8'h68);
        push_stdin(8'h69);
        wait_tx(2, "a_stdin_count");
        check("a_stdin0", 32'(tx_q[tx_base]), 32'h68);
        check("a_stdin1", 32'(tx_q[tx_base + 1]), 32'h69);
        send_rx(8'h41);
        check("a_stdout_v", 32'(stdout_valid), 32'd1);
        check("a_stdout_d", 32'(stdout_data), 32'h41);
        @(negedge clk);
        check("a_stdout_pulse", 32'(stdout_valid), 32'd0);
        send_rx(8'h99);
        check("a_stdout_99", 32'(stdout_data), 32'h99);
        check("a_stream_err", 32'(proto_err), 32'd0);

        // Zero-length program
        do_reset();
        check("z_boot_cleared", 32'(boot_done), 32'd0);
        do_start(32'd0);
        send_rx(SYNC_START);
        wait_tx(4, "z_tx_count");
        check_boot_seq(32'd0, "z");
        cycles(40);
        check("z_only4", 32'(tx_q.size() - tx_base), 32'd4);
        check("z_wait_aa", 32'(dut.state), 32'(WAIT_AA));
        send_rx(SYNC_DONE);
        check("z_boot_done", 32'(boot_done), 32'd1);

        // Unexpected byte while waiting for 0x99
        do_reset();
        do_start(32'd8);
        send_rx(8'h55);
        check("e_err",   32'(proto_err), 32'd1);
        check("e_state", 32'(dut.state), 32'(WAIT_99));
        send_rx(SYNC_START);
        check("e_send_size", 32'(dut.state), 32'(SEND_SIZE));
        wait_tx(12, "e_tx_count");
        check_boot_seq(32'd8, "e");

        // stdin FIFO overflow before streaming
        do_reset();
        for (int i = 0; i < 16; i++) push_stdin(8'(8'h10 + i));
        check("f_full",       32'(stdin_full), 32'd1);
        check("f_err_before", 32'(proto_err), 32'd0);
        push_stdin(8'hEE);
        check("f_err_after",  32'(proto_err), 32'd1);
        do_start(32'd0);
        send_rx(SYNC_START);
        wait_tx(4, "f_size_count");
        send_rx(SYNC_DONE);
        wait_tx(20, "f_stream_count");
        cycles(60);
        check("f_exact20", 32'(tx_q.size() - tx_base), 32'd20);
        for (int i = 0; i < 16; i++)
            check($sformatf("f_byte%0d", i), 32'(tx_q[tx_base + 4 + i]), 32'(8'h10 + i));
        check("f_not_full", 32'(stdin_full), 32'd0);

        // Reset in the middle of the program download, then restart
        do_reset();
        do_start(32'd8);
        send_rx(SYNC_START);
        wait_tx(6, "r_mid_count");
        reset_n = 1'b0;
        @(negedge clk);
        check("r_tx_start",  32'(tx_start), 32'd0);
        check("r_tx_data",   32'(tx_data), 32'd0);
        check("r_addr",      32'(prog_rd_addr), 32'd0);
        check("r_proto_err", 32'(proto_err), 32'd0);
        check("r_stdout",    32'(stdout_valid), 32'd0);
        check("r_state",     32'(dut.state), 32'(IDLE));
        @(negedge clk);
        reset_n = 1'b1;
        cycles(6);
        tx_base = tx_q.size();
        do_start(32'd8);
        send_rx(SYNC_START);
        wait_tx(12, "r_tx_count");
        check_boot_seq(32'd8, "r");

`ifdef BOOT_SERVER_TIMEOUT_EN
        // Watchdog with TIMEOUT_CYCLES=100
        do_reset();
        do_start(32'd8);
        cycles(50);
        check("t_still_wait", 32'(dut.state), 32'(WAIT_99));
        check("t_no_err",     32'(proto_err), 32'd0);
        cycles(60);
        check("t_err",   32'(proto_err), 32'd1);
        check("t_state", 32'(dut.state), 32'(IDLE));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
